pcileech_pcie_tx_arb: RTL and testbench

Packet-level arbiter that shares the PCIe core's single 64-bit AXI-Stream transmit port (s_axis_tx) between N_SRC independent TLP sources. Typical sources are the FIFO TLP path, static TLPs from the cfg block, and shadow config-space completions.
It sits in the clk_pcie domain between those sources and the core. It never interleaves beats of different packets and gates new packets on core buffer availability.
It also drives tx_cfg_gnt so core-internal config completions are only sent between user packets. It provides packet-count and stall status.

---
 rtl/pcileech_pcie_tx_arb_if.sv | 35 +++
 rtl/pcileech_pcie_tx_arb.sv | 175 +++++++++++++++++
 tb/tb_pcileech_pcie_tx_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_pcie_tx_arb_if.sv
// Transmit-side bundle between N_SRC TLP sources, the arbiter and the PCIe core's s_axis_tx port.
// Carries the per-source streams, the core stream, buffer availability and the cfg request/grant pair.
interface pcileech_pcie_tx_arb_if #(
  parameter int N_SRC = 3
);
  logic [64*N_SRC-1:0] src_data;
  logic [8*N_SRC-1:0]  src_keep;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_ready;
  logic [63:0]         tx_data;
  logic [7:0]          tx_keep;
  logic                tx_last;
  logic                tx_valid;
  logic                tx_ready;
  logic [5:0]          tx_buf_av;
  logic                tx_cfg_req;
  logic                tx_cfg_gnt;

  modport master (
    input  src_data, src_keep, src_last, src_valid,
    output src_ready,
    output tx_data, tx_keep, tx_last, tx_valid,
    input  tx_ready, tx_buf_av, tx_cfg_req,
    output tx_cfg_gnt
  );

  modport slave (
    output src_data, src_keep, src_last, src_valid,
    input  src_ready,
    input  tx_data, tx_keep, tx_last, tx_valid,
    output tx_ready, tx_buf_av, tx_cfg_req,
    input  tx_cfg_gnt
  );
endinterface

// File: rtl/pcileech_pcie_tx_arb.sv
// Packet-level round-robin arbiter sharing the PCIe core's 64-bit transmit stream between N_SRC sources.
// Whole packets only; new packets gated on buffer availability; core cfg TLPs granted between packets.
module pcileech_pcie_tx_arb #(
  parameter int N_SRC      = 3,
  parameter int BUF_AV_MIN = 2,
  parameter int STALL_MAX  = 1024
) (
  input  logic                   clk_pcie,
  input  logic                   rst_n,
  pcileech_pcie_tx_arb_if.master bus,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [31:0]            pkt_cnt,
  output logic                   stall_err
);

  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_PKT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            cfg_gnt_q, cfg_gnt_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic            stall_err_q, stall_err_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;

  // Sources padded to the 8-source maximum so a 3-bit grant indexes them exactly.
  logic [7:0]      valid_pad_s;
  logic [7:0]      last_pad_s;
  logic [63:0]     keep_pad_s;
  logic [511:0]    data_pad_s;
  logic [7:0]      ready_pad_s;
  logic            in_pkt_s;
  logic            g_valid_s;
  logic            xfer_s;

  // First requester strictly after the previous grant, wrapping at N_SRC.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(last) + i) % N_SRC;
      if (!found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign valid_pad_s = 8'(bus.src_valid);
  assign last_pad_s  = 8'(bus.src_last);
  assign keep_pad_s  = 64'(bus.src_keep);
  assign data_pad_s  = 512'(bus.src_data);
  assign in_pkt_s    = (state_q == S_PKT);
  assign g_valid_s   = valid_pad_s[grant_q];

  // Combinational pass-through of the granted source while a packet is open.
  always_comb begin
    bus.tx_valid = in_pkt_s & g_valid_s;
    bus.tx_data  = in_pkt_s ? data_pad_s[{grant_q, 6'd0} +: 64] : 64'd0;
    bus.tx_keep  = in_pkt_s ? keep_pad_s[{grant_q, 3'd0} +: 8] : 8'd0;
    bus.tx_last  = in_pkt_s ? last_pad_s[grant_q] : 1'b0;
    ready_pad_s  = 8'd0;
    if (in_pkt_s) begin
      ready_pad_s[grant_q] = bus.tx_ready;
    end else begin
      ready_pad_s = 8'd0;
    end
    bus.src_ready = ready_pad_s[N_SRC-1:0];
  end

  assign xfer_s = bus.tx_valid & bus.tx_ready;

  // Next-state, grant, packet counter and stall supervision.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    cfg_gnt_d   = cfg_gnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    stall_err_d = stall_err_q;
    stall_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.tx_cfg_req) begin
          state_d   = S_CFG;
          cfg_gnt_d = 1'b1;
          busy_d    = 1'b0;
        end else if ((|bus.src_valid) && (bus.tx_buf_av >= 6'(BUF_AV_MIN))) begin
          state_d   = S_PKT;
          grant_d   = rr_pick(valid_pad_s, grant_q);
          busy_d    = 1'b1;
          cfg_gnt_d = 1'b0;
        end else begin
          cfg_gnt_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      S_CFG: begin
        cfg_gnt_d = 1'b1;
        if (!bus.tx_cfg_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CFG;
        end
      end
      S_PKT: begin
        if (xfer_s) begin
          stall_cnt_d = '0;
          if (bus.tx_last) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            busy_d    = 1'b0;
            cfg_gnt_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_PKT;
          end
        end else if (!g_valid_s && (stall_cnt_q != SW'(STALL_MAX))) begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        cfg_gnt_d = 1'b1;
      end
    endcase
    // The flag is sticky: the packet keeps going, only reset clears it.
    if (stall_cnt_d == SW'(STALL_MAX)) begin
      stall_err_d = 1'b1;
    end else begin
      stall_err_d = stall_err_d;
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk_pcie) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 3'(N_SRC - 1);
      busy_q      <= 1'b0;
      cfg_gnt_q   <= 1'b1;
      pkt_cnt_q   <= 32'd0;
      stall_err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      cfg_gnt_q   <= cfg_gnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      stall_err_q <= stall_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.tx_cfg_gnt = cfg_gnt_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign pkt_cnt        = pkt_cnt_q;
  assign stall_err      = stall_err_q;

endmodule

// File: tb/tb_pcileech_pcie_tx_arb.sv
// Scoreboard bench for pcileech_pcie_tx_arb: sources are modelled as beat queues, expected beats
// are queued in arbitration order when loaded and compared as they leave on the core stream.
module tb_pcileech_pcie_tx_arb;

  localparam int NS = 3;

  typedef struct packed {
    logic [2:0]  src;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  logic        clk_pcie;
  logic        rst_n;
  logic        busy;
  logic [2:0]  grant_id;
  logic [31:0] pkt_cnt;
  logic        stall_err;

  pcileech_pcie_tx_arb_if #(.N_SRC(NS)) bus ();

  pcileech_pcie_tx_arb #(.N_SRC(NS), .BUF_AV_MIN(2), .STALL_MAX(8)) dut (
    .clk_pcie (clk_pcie),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_cnt  (pkt_cnt),
    .stall_err(stall_err)
  );

  beat_t       src_q [NS][$];
  beat_t       exp_q [$];
  logic [NS-1:0] hold;
  logic [NS-1:0] xfer_mask;
  int          chk_cnt;
  int          pass_cnt;

  initial clk_pcie = 1'b0;
  always #5 clk_pcie = ~clk_pcie;

  // Drive every source from the head of its queue.
  task automatic drive_srcs();
    logic [64*NS-1:0] d;
    logic [8*NS-1:0]  k;
    logic [NS-1:0]    l, v;
    d = '0; k = '0; l = '0; v = '0;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        d[64*i +: 64] = src_q[i][0].data;
        k[8*i +: 8]   = src_q[i][0].keep;
        l[i]          = src_q[i][0].last;
        v[i]          = !hold[i];
      end
    end
    bus.src_data  = d;
    bus.src_keep  = k;
    bus.src_last  = l;
    bus.src_valid = v;
  endtask

  task automatic tick();
    @(posedge clk_pcie);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (xfer_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_srcs();
  endtask

  task automatic load_pkt(input int s, input int n, input int tag);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src  = 3'(s);
      b.last = (i == n - 1);
      b.keep = b.last ? 8'h0F : 8'hFF;
      b.data = {$urandom, 8'(s), 8'(tag), 16'(i)};
      src_q[s].push_back(b);
      exp_q.push_back(b);
    end
    drive_srcs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    hold = '0;
    drive_srcs();
  endtask

  // Scoreboard: compare each transferring beat and the ready fan-out against the queued expectation.
  always @(negedge clk_pcie) begin
    beat_t e;
    xfer_mask = rst_n ? (bus.src_valid & bus.src_ready) : '0;
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected: got data %0h from grant %0d, want no transfer", bus.tx_data, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_data !== e.data || bus.tx_keep !== e.keep || bus.tx_last !== e.last ||
            grant_id !== e.src || bus.src_ready !== (NS'(1) << e.src))
          $display("FAIL beat: got data %0h keep %0h last %0b src %0d ready %b, want data %0h keep %0h last %0b src %0d",
                   bus.tx_data, bus.tx_keep, bus.tx_last, grant_id, bus.src_ready, e.data, e.keep, e.last, e.src);
        else pass_cnt++;
      end
    end else if (rst_n && bus.tx_valid && !bus.tx_ready) begin
      chk_cnt++;
      if (bus.src_ready !== '0) $display("FAIL ready_mirror: got src_ready %b, want 000", bus.src_ready);
      else pass_cnt++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (bus.tx_valid !== 1'b0 || bus.src_ready !== '0 || busy !== 1'b0 || bus.tx_cfg_gnt !== 1'b1 ||
        grant_id !== 3'd2 || pkt_cnt !== 32'd0 || stall_err !== 1'b0)
      $display("FAIL reset: got valid %b ready %b busy %b gnt %b grant %0d cnt %0d err %b, want 0 000 0 1 2 0 0",
               bus.tx_valid, bus.src_ready, busy, bus.tx_cfg_gnt, grant_id, pkt_cnt, stall_err);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) load_pkt(s, 2, p);
    tick();
    chk_cnt++;
    if (busy !== 1'b1 || grant_id !== 3'd0) $display("FAIL rr_first_grant: got busy %b grant %0d, want 1 0", busy, grant_id);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) tick();
    chk_cnt++;
    if (pkt_cnt !== 32'd5) $display("FAIL rr_cnt17: got %0d, want 5", pkt_cnt);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (pkt_cnt !== 32'd6 || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rr_done: got cnt %0d busy %b left %0d, want 6 0 0", pkt_cnt, busy, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit done;
    done = 1'b0;
    load_pkt(1, 5, 7);
    bus.tx_ready = 1'b1;
    tick();
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      bus.tx_ready = ~bus.tx_ready;
      done = (exp_q.size() == 0) && (busy == 1'b0);
    end
    bus.tx_ready = 1'b1;
    chk_cnt++;
    if (!done || pkt_cnt !== 32'd7) $display("FAIL bp_done: got done %b cnt %0d, want 1 7", done, pkt_cnt);
    else pass_cnt++;
  endtask

  task automatic test_buf_gating();
    bus.tx_buf_av = 6'd1;
    load_pkt(2, 2, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (busy !== 1'b0 || bus.tx_valid !== 1'b0) $display("FAIL gate_hold: got busy %b valid %b, want 0 0", busy, bus.tx_valid);
      else pass_cnt++;
    end
    bus.tx_buf_av = 6'd2;
    tick();
    chk_cnt++;
    if (busy !== 1'b1 || grant_id !== 3'd2 || bus.tx_valid !== 1'b1)
      $display("FAIL gate_grant: got busy %b grant %0d valid %b, want 1 2 1", busy, grant_id, bus.tx_valid);
    else pass_cnt++;
    tick(); tick();
    chk_cnt++;
    if (pkt_cnt !== 32'd8 || busy !== 1'b0) $display("FAIL gate_done: got cnt %0d busy %b, want 8 0", pkt_cnt, busy);
    else pass_cnt++;
    bus.tx_buf_av = 6'd10;
  endtask

  task automatic test_cfg_priority();
    load_pkt(0, 3, 1);
    load_pkt(0, 1, 2);
    tick();
    bus.tx_cfg_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_cnt++;
      if (bus.tx_cfg_gnt !== 1'b0) $display("FAIL cfg_midpkt: got gnt %b, want 0", bus.tx_cfg_gnt);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if (bus.tx_cfg_gnt !== 1'b1 || pkt_cnt !== 32'd9) $display("FAIL cfg_pktend: got gnt %b cnt %0d, want 1 9", bus.tx_cfg_gnt, pkt_cnt);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++;
    if (bus.tx_cfg_gnt !== 1'b1 || busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.src_ready !== '0)
      $display("FAIL cfg_block: got gnt %b busy %b valid %b ready %b, want 1 0 0 000", bus.tx_cfg_gnt, busy, bus.tx_valid, bus.src_ready);
    else pass_cnt++;
    bus.tx_cfg_req = 1'b0;
    tick();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL cfg_release: got busy %b, want 0", busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy !== 1'b1 || grant_id !== 3'd0 || bus.tx_cfg_gnt !== 1'b0)
      $display("FAIL cfg_regrant: got busy %b grant %0d gnt %b, want 1 0 0", busy, grant_id, bus.tx_cfg_gnt);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (pkt_cnt !== 32'd10 || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL single_beat: got cnt %0d busy %b left %0d, want 10 0 0", pkt_cnt, busy, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit done;
    done = 1'b0;
    load_pkt(0, 3, 4);
    tick();
    hold[0] = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk_cnt++;
    if (stall_err !== 1'b0) $display("FAIL stall_early: got %b, want 0", stall_err);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (stall_err !== 1'b1) $display("FAIL stall_set: got %b, want 1", stall_err);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    hold[0] = 1'b0;
    drive_srcs();
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && (busy == 1'b0);
    end
    chk_cnt++;
    if (!done || stall_err !== 1'b1 || pkt_cnt !== 32'd11)
      $display("FAIL stall_resume: got done %b err %b cnt %0d, want 1 1 11", done, stall_err, pkt_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_packet();
    load_pkt(0, 4, 5);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if (bus.tx_valid !== 1'b0 || bus.src_ready !== '0 || pkt_cnt !== 32'd0 || bus.tx_cfg_gnt !== 1'b1 ||
        busy !== 1'b0 || grant_id !== 3'd2)
      $display("FAIL reset_midpkt: got valid %b ready %b cnt %0d gnt %b busy %b grant %0d, want 0 000 0 1 0 2",
               bus.tx_valid, bus.src_ready, pkt_cnt, bus.tx_cfg_gnt, busy, grant_id);
    else pass_cnt++;
    clear_all();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    hold = '0; xfer_mask = '0;
    rst_n = 1'b0;
    bus.tx_ready = 1'b1;
    bus.tx_buf_av = 6'd10;
    bus.tx_cfg_req = 1'b0;
    drive_srcs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_buf_gating();
    test_cfg_priority();
    test_stall();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
